// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory port-B arbiter.
//   owner_e : which requester owns a BRAM access (CORE or HOST)
//   state_e : arbiter FSM state (IDLE or CLEAR)
//   BE_ALL  : full-word byte-enable mask used by the clear sweep
//   web_of  : byte write enables for a granted access
package dmem_arb_pkg;

  typedef enum logic {
    CORE = 1'b0,
    HOST = 1'b1
  } owner_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  // Reads never touch the byte write enables.
  function automatic logic [3:0] web_of(input logic we, input logic [3:0] be);
    return we ? be : 4'h0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : request vector, bit CORE (0) and bit HOST (1)
//   advance    : arbitration enable; no grant is issued while low
//   gnt[1:0]   : one-hot combinational grant, same bit order as req
// On a tie the requester that did not win last is granted. The memory of the
// last winner resets to HOST so the core takes the first tie.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e last_owner_r;

  // Grant selection: single requester wins outright, tie goes to the non-last owner.
  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_owner_r == HOST) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Remember the winner of every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_r <= HOST;
    end else if (gnt[0]) begin
      last_owner_r <= CORE;
    end else if (gnt[1]) begin
      last_owner_r <= HOST;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: owns BRAM port B of the data memory, sharing it between
// the core load/store unit and the host path, plus a full-memory clear sweep.
//   core_* / host_*  : requesters (req/we/be/addr/wdata in, gnt/rvalid out)
//   rdata            : BRAM read data, valid while the owner's rvalid is high
//   clr_start        : pulse that starts the clear sweep (honoured in IDLE)
//   clr_busy         : sweep in progress
//   clr_done         : one-cycle pulse after the last clear write
//   data_mem_*       : BRAM port-B pins; data_mem_rstb_busy stalls everything
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [3:0]  host_be,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        data_mem_clkb,
  output logic        data_mem_enb,
  output logic        data_mem_rstb,
  output logic [3:0]  data_mem_web,
  output logic [31:0] data_mem_addrb,
  output logic [31:0] data_mem_dinb,
  input  logic [31:0] data_mem_doutb,
  input  logic        data_mem_rstb_busy
);

  state_e           state_r;
  logic [IDX_W-1:0] idx_r;
  logic             core_rvalid_r;
  logic             host_rvalid_r;
  logic             clr_done_r;
  logic [1:0]       gnt_s;
  logic             arb_adv_s;
  logic             clr_wr_s;
  logic             last_idx_s;

  assign arb_adv_s  = (state_r == IDLE) && !data_mem_rstb_busy;
  assign clr_wr_s   = (state_r == CLEAR) && !data_mem_rstb_busy;
  assign last_idx_s = (idx_r == IDX_W'(MEM_DEPTH - 1));

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({host_req, core_req}),
    .advance (arb_adv_s),
    .gnt     (gnt_s)
  );

  assign core_gnt      = gnt_s[0];
  assign host_gnt      = gnt_s[1];
  assign core_rvalid   = core_rvalid_r;
  assign host_rvalid   = host_rvalid_r;
  assign clr_done      = clr_done_r;
  assign clr_busy      = (state_r == CLEAR);
  assign rdata         = data_mem_doutb;
  assign data_mem_clkb = clk;
  assign data_mem_rstb = 1'b0;

  // BRAM port-B mux: granted requester, else clear write, else quiet bus.
  always_comb begin
    data_mem_enb   = 1'b0;
    data_mem_web   = 4'h0;
    data_mem_addrb = 32'h0;
    data_mem_dinb  = 32'h0;
    if (gnt_s[0]) begin
      data_mem_enb   = 1'b1;
      data_mem_web   = web_of(core_we, core_be);
      data_mem_addrb = core_addr;
      data_mem_dinb  = core_wdata;
    end else if (gnt_s[1]) begin
      data_mem_enb   = 1'b1;
      data_mem_web   = web_of(host_we, host_be);
      data_mem_addrb = host_addr;
      data_mem_dinb  = host_wdata;
    end else if (clr_wr_s) begin
      data_mem_enb   = 1'b1;
      data_mem_web   = BE_ALL;
      data_mem_addrb = {{(30 - IDX_W){1'b0}}, idx_r, 2'b00};
      data_mem_dinb  = 32'h0;
    end else begin
      data_mem_enb   = 1'b0;
    end
  end

  // FSM, clear counter, read-valid tags and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      core_rvalid_r <= 1'b0;
      host_rvalid_r <= 1'b0;
      clr_done_r    <= 1'b0;
    end else begin
      // The rvalid bits double as the owner tag of the read in flight.
      core_rvalid_r <= gnt_s[0] & ~core_we;
      host_rvalid_r <= gnt_s[1] & ~host_we;
      clr_done_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clr_start) begin
            state_r <= CLEAR;
            idx_r   <= '0;
          end
        end
        CLEAR: begin
          if (clr_wr_s) begin
            if (last_idx_s) begin
              state_r    <= IDLE;
              idx_r      <= '0;
              clr_done_r <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench for dmem_port_arbiter with a BRAM
// behavioural model on port B and a read scoreboard checked by a monitor.
module tb_dmem_port_arbiter;

  localparam int MEM_DEPTH = 4096;
  localparam int IDX_W     = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [3:0]  core_be = 4'h0;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
  logic        core_gnt, core_rvalid;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [3:0]  host_be = 4'h0;
  logic [31:0] host_addr = 32'h0, host_wdata = 32'h0;
  logic        host_gnt, host_rvalid;
  logic [31:0] rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy, clr_done;
  logic        data_mem_clkb, data_mem_enb, data_mem_rstb;
  logic [3:0]  data_mem_web;
  logic [31:0] data_mem_addrb, data_mem_dinb;
  logic [31:0] data_mem_doutb = 32'h0;
  logic        data_mem_rstb_busy = 1'b0;

  typedef struct {
    bit          host;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [MEM_DEPTH];

  dmem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_we(host_we), .host_be(host_be),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .rdata(rdata), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .data_mem_clkb(data_mem_clkb), .data_mem_enb(data_mem_enb),
    .data_mem_rstb(data_mem_rstb), .data_mem_web(data_mem_web),
    .data_mem_addrb(data_mem_addrb), .data_mem_dinb(data_mem_dinb),
    .data_mem_doutb(data_mem_doutb), .data_mem_rstb_busy(data_mem_rstb_busy)
  );

  always #5 clk = ~clk;

  // BRAM port-B model: read-first, byte-masked writes.
  always @(posedge data_mem_clkb) begin
    if (data_mem_enb) begin
      data_mem_doutb <= mem[data_mem_addrb[IDX_W+1:2]];
      for (int b = 0; b < 4; b++)
        if (data_mem_web[b]) mem[data_mem_addrb[IDX_W+1:2]][8*b +: 8] = data_mem_dinb[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pops the oldest expected read and compares owner and data.
  always @(negedge clk) begin
    if (rst_n && (core_rvalid || host_rvalid)) begin
      if (core_rvalid && host_rvalid) begin
        check("rvalid_both", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid_owner", {31'd0, host_rvalid}, {31'd0, e.host});
        check("rdata", rdata, e.data);
      end
    end
  end

  task automatic push(input bit host, input logic [31:0] data);
    exp_t e;
    e.host = host;
    e.data = data;
    sb.push_back(e);
  endtask

  // One access on one requester; req held until grant. Call at posedge+1.
  task automatic access(input bit host, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, output int waits);
    bit granted = 1'b0;
    waits = 0;
    if (host) begin
      host_req = 1'b1; host_we = we; host_be = be; host_addr = addr; host_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
    end
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (host ? host_gnt : core_gnt) granted = 1'b1;
      else waits++;
    end
    if (!granted) check("gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (host) begin host_req = 1'b0; host_we = 1'b0; end
    else begin core_req = 1'b0; core_we = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full sweep with the core requesting throughout; optional busy stall window.
  task automatic run_clear(input int stall_at, input int stall_len, input int exp_busy);
    int busy = 0, bad_gnt = 0, addr_err = 0, enb_err = 0, exp_idx = 0, nonzero = 0;
    bit done = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      data_mem_rstb_busy = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      @(negedge clk);
      if (clr_busy) begin
        busy++;
        if (core_gnt) bad_gnt++;
        if (data_mem_rstb_busy) begin
          if (data_mem_enb) enb_err++;
        end else begin
          if (!data_mem_enb || data_mem_addrb != 32'(exp_idx * 4) ||
              data_mem_web != 4'hF || data_mem_dinb != 32'h0) addr_err++;
          exp_idx++;
        end
      end
      if (clr_done) begin
        done = 1'b1;
        push(1'b0, 32'h0);  // core read of word 0 granted as soon as IDLE returns
      end
      @(posedge clk); #1;
    end
    core_req = 1'b0;
    data_mem_rstb_busy = 1'b0;
    check("clr_busy_cycles", busy, exp_busy);
    check("clr_no_grant", bad_gnt, 0);
    check("clr_addr_seq", addr_err, 0);
    check("clr_stall_enb", enb_err, 0);
    check("clr_done_seen", {31'd0, done}, 32'd1);
    check("clr_word_count", exp_idx, MEM_DEPTH);
    @(negedge clk);
    check("clr_done_pulse_width", {31'd0, clr_done}, 32'd0);
    idle(2);
    for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] != 32'h0) nonzero++;
    check("clr_mem_zero", nonzero, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w, ci, hi, dones;
    bit hit;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("rst_clr_done", {31'd0, clr_done}, 32'd0);
    check("rst_rvalid", {30'd0, host_rvalid, core_rvalid}, 32'd0);
    check("rst_enb", {31'd0, data_mem_enb}, 32'd0);
    check("rst_rstb", {31'd0, data_mem_rstb}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    // Contention: core first (last owner resets to HOST), then strict alternation.
    mem['h20] = 32'hA0A0_0001; mem['h21] = 32'hA0A0_0002;
    mem['h30] = 32'hB0B0_0001; mem['h31] = 32'hB0B0_0002;
    push(1'b0, 32'hA0A0_0001); push(1'b1, 32'hB0B0_0001);
    push(1'b0, 32'hA0A0_0002); push(1'b1, 32'hB0B0_0002);
    ci = 0; hi = 0;
    core_req = 1'b1; core_addr = 32'h80;
    host_req = 1'b1; host_addr = 32'hC0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check("cont_core_gnt", {31'd0, core_gnt}, {31'd0, cyc % 2 == 0});
      check("cont_host_gnt", {31'd0, host_gnt}, {31'd0, cyc % 2 == 1});
      if (core_gnt) ci++;
      if (host_gnt) hi++;
      @(posedge clk); #1;
      core_req = (ci < 2); core_addr = (ci == 0) ? 32'h80 : 32'h84;
      host_req = (hi < 2); host_addr = (hi == 0) ? 32'hC0 : 32'hC4;
    end
    core_req = 1'b0; host_req = 1'b0;
    idle(3);

    // Core-only read: granted in the request cycle.
    mem['h10] = 32'hDEAD_BEEF;
    push(1'b0, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, w);
    check("core_gnt_latency", w, 0);
    idle(3);

    // Host byte write, then host readback; the write itself raises no rvalid.
    mem[0] = 32'h1122_3344;
    access(1'b1, 1'b1, 4'b0001, 32'h0, 32'h0000_00AB, w);
    idle(1);
    check("byte_write_mem", mem[0], 32'h1122_33AB);
    push(1'b1, 32'h1122_33AB);
    access(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, w);
    idle(3);

    run_clear(5000, 0, MEM_DEPTH);
    run_clear(200, 5, MEM_DEPTH + 5);

    // Reset mid-sweep at idx=100, then a fresh sweep starts at address 0.
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
      @(negedge clk);
      if (data_mem_enb && data_mem_addrb == 32'd400) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("abort_reach_idx100", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("abort_enb", {31'd0, data_mem_enb}, 32'd0);
    dones = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin #1 rst_n = 1'b1; end
      if (clr_done || clr_busy) dones++;
    end
    check("abort_no_done_idle", dones, 0);
    @(posedge clk); #1;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(negedge clk);
    check("restart_busy", {31'd0, clr_busy}, 32'd1);
    check("restart_addr0", data_mem_addrb, 32'h0);
    check("restart_enb", {31'd0, data_mem_enb}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
